// File: rtl/frac_clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frac_clk_div_pkg
// Brief   : Shared constants, state encoding and ratio clamp helper for the
//           fractional clock divider.
// Revision: 1.0 - initial release
// ============================================================================
package frac_clk_div_pkg;

  // Smallest legal ratio x2 (divide by 1).
  localparam int unsigned RATIO_MIN_X2 = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Any requested ratio below the minimum is raised to the minimum.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio_x2);
    return (ratio_x2 < RATIO_MIN_X2) ? RATIO_MIN_X2 : ratio_x2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_edge_reg.sv
`default_nettype none
// ============================================================================
// Module  : frac_edge_reg
// Brief   : Dual-edge output stage. Both half-cycle values are registered on
//           the rising edge; the second-half value is retimed onto the falling
//           edge and the output mux selects by the level of clk.
// Revision: 1.0 - initial release
// ============================================================================
module frac_edge_reg (
  input  logic clk_i,
  input  logic reset_i,
  input  logic first_d_i,   // value for the clk-high half of the next cycle
  input  logic second_d_i,  // value for the clk-low half of the next cycle
  output logic clk_o
);

  logic first_q;
  logic second_q;
  logic neg_q;

  // Capture both half-cycle values at the rising edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      first_q  <= 1'b0;
      second_q <= 1'b0;
    end else begin
      first_q  <= first_d_i;
      second_q <= second_d_i;
    end
  end

  // Half-cycle retime of the second-half value; cleared while reset is high.
  always_ff @(negedge clk_i) begin
    if (reset_i) neg_q <= 1'b0;
    else         neg_q <= second_q;
  end

  assign clk_o = clk_i ? first_q : neg_q;

endmodule
`default_nettype wire

// File: rtl/frac_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : frac_clk_div
// Brief   : Programmable fractional clock divider. Output period is ratio_x2
//           half-periods of clk (high ceil, low floor). Ratio changes apply
//           glitch-free at a rising-edge period boundary.
//           Macro FRAC_DIV_DUAL_EDGE_EN enables half-integer ratios using the
//           falling edge; without it the divider is integer-only (R/2).
// Revision: 1.0 - initial release
// ============================================================================
module frac_clk_div
  import frac_clk_div_pkg::*;
#(
  parameter int W                = 8,
  parameter int DEFAULT_RATIO_X2 = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] ratio_x2,
  input  logic         ratio_load,
  output logic         clk_out,
  output logic         cfg_ack,
  output logic         running
);

`ifdef FRAC_DIV_DUAL_EDGE_EN
  localparam int STEP = 2;  // two half-cycle ticks per clk cycle
`else
  localparam int STEP = 1;  // one whole-cycle tick per clk cycle
`endif

  // Convert a requested ratio x2 into ticks of the counter.
  function automatic logic [W-1:0] to_ticks(input logic [W-1:0] rx2);
    logic [31:0] c;
`ifdef FRAC_DIV_DUAL_EDGE_EN
    c = clamp_ratio(32'(rx2));
`else
    c = clamp_ratio(32'(rx2 & ~W'(1))) >> 1;
`endif
    return W'(c);
  endfunction

  localparam logic [W-1:0] C_DEFAULT_TICKS = to_ticks(W'(DEFAULT_RATIO_X2));

  state_e       state_q, state_d;
  logic [W-1:0] ph_q, ph_d;       // tick index of the clk-high half of this cycle
  logic [W-1:0] r_q, r_d;         // active ratio in ticks
  logic [W-1:0] pend_q, pend_d;   // pending ratio in ticks
  logic         pend_v_q, pend_v_d;
  logic         cfg_ack_q, ack_d;
  logic         running_q, run_d;
  logic         hi0_d;

  logic [W:0]   w_adv;
  logic [W-1:0] w_r;
  logic [W:0]   w_half;
  logic         w_apply;
  logic         w_emit;
`ifdef FRAC_DIV_DUAL_EDGE_EN
  logic         hi1_d;
  logic         w_stop_neg;
  logic [W:0]   w_t1;
`endif

  // Next-state: period counter, ratio application and per-half output values.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    r_d      = r_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ack_d    = 1'b0;
    run_d    = 1'b0;
    hi0_d    = 1'b0;
    w_apply  = 1'b0;
    w_emit   = 1'b0;
`ifdef FRAC_DIV_DUAL_EDGE_EN
    hi1_d      = 1'b0;
    w_stop_neg = 1'b0;
    w_t1       = '0;
`endif
    w_adv = {1'b0, ph_q} + (W+1)'(STEP);
    if (w_adv >= {1'b0, r_q}) w_adv = w_adv - {1'b0, r_q};

    case (state_q)
      RUN, DRAIN: begin
        // w_adv == 0 means this rising edge is a period boundary.
        if (w_adv == '0) w_apply = pend_v_q;
        if (!en && (w_adv == '0)) begin
          state_d = IDLE;
        end else begin
          w_emit  = 1'b1;
          ph_d    = w_adv[W-1:0];
          state_d = en ? RUN : DRAIN;
`ifdef FRAC_DIV_DUAL_EDGE_EN
          // Boundary falls on the coming falling edge: finish there.
          if (!en && ((w_adv + (W+1)'(1)) == {1'b0, r_q})) begin
            state_d    = IDLE;
            w_stop_neg = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_apply = pend_v_q;
        if (en) begin
          state_d = RUN;
          ph_d    = '0;
          w_emit  = 1'b1;
        end
      end
    endcase

    if (w_apply) begin
      r_d      = pend_q;
      pend_v_d = 1'b0;
      ack_d    = 1'b1;
    end
    // A load coinciding with an application stays pending.
    if (ratio_load) begin
      pend_d   = to_ticks(ratio_x2);
      pend_v_d = 1'b1;
    end

    w_r    = w_apply ? pend_q : r_q;
    w_half = ({1'b0, w_r} + (W+1)'(1)) >> 1;
    if (w_emit) begin
      run_d = 1'b1;
      hi0_d = ({1'b0, ph_d} < w_half);
`ifdef FRAC_DIV_DUAL_EDGE_EN
      w_t1 = {1'b0, ph_d} + (W+1)'(1);
      if (w_t1 < {1'b0, w_r}) hi1_d = (w_t1 < w_half);
      else                    hi1_d = !w_stop_neg;
`endif
    end
  end

  // Posedge state registers; reset discards any pending ratio.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      r_q       <= C_DEFAULT_TICKS;
      pend_q    <= C_DEFAULT_TICKS;
      pend_v_q  <= 1'b0;
      cfg_ack_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      r_q       <= r_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      cfg_ack_q <= ack_d;
      running_q <= run_d;
    end
  end

`ifdef FRAC_DIV_DUAL_EDGE_EN
  frac_edge_reg u_edge (
    .clk_i      (clk),
    .reset_i    (reset),
    .first_d_i  (hi0_d),
    .second_d_i (hi1_d),
    .clk_o      (clk_out)
  );
`else
  logic out_q;

  // Integer-only output: one registered level per clk cycle.
  always_ff @(posedge clk) begin
    if (reset) out_q <= 1'b0;
    else       out_q <= hi0_d;
  end

  assign clk_out = out_q;
`endif

  assign cfg_ack = cfg_ack_q;
  assign running = running_q;

endmodule
`default_nettype wire

// File: doc/frac_clk_div.md
# frac_clk_div

Programmable fractional clock divider producing `clk_out` with period `ratio_x2/2` input clock periods, so both integer and half-integer ratios are supported. Edges are placed on both `clk` edges to give near-50% duty. The divide ratio can be changed at run time and takes effect glitch-free at a period boundary. The block is the general successor to the fixed divide-by-1.5 and divide-by-3 blocks and sits at the clock-generation edge of the design.

## Interface
- `W`, 8: width of `ratio_x2`.
- `DEFAULT_RATIO_X2`, 3: ratio (×2) in force after reset; 3 means divide by 1.5.
- `clk` input 1: input clock. Both edges are used.
- `reset` input 1: synchronous, active-high. Clock is `clk`.
- `en` input 1: run request.
- `ratio_x2` input W: requested ratio ×2.
- `ratio_load` input 1: one-cycle strobe; captures `ratio_x2`.
- `clk_out` output 1: divided clock.
- `cfg_ack` output 1: one-cycle pulse when a loaded ratio becomes active.
- `running` output 1: divider is producing periods.

## Operation
- Let T be the `clk` period and R = active `ratio_x2`.
- Output period is R half-periods of `clk`.
- High phase is ceil(R/2) half-periods; low phase is floor(R/2) half-periods.
- Every `clk_out` edge coincides with a `clk` edge, either rising or falling.
- Clamping: any `ratio_x2` < 2 is clamped to 2. R = 2 gives `clk_out` equal to `clk`, gated by `running`.
- Start: `en` sampled high at a posedge while `running` = 0.
  - `running` goes to 1 at that posedge.
  - `clk_out` rises at that same edge. That edge is the first period boundary.
- Boundaries: for odd R, period boundaries alternate between posedge and negedge. For even R, all boundaries are posedges.
- Stop: `en` sampled low. The current period completes, including its low phase.
  - `clk_out` stays low from the next boundary onward.
  - `running` clears at the first posedge at or after that boundary.
- Load: `ratio_load` high at a posedge captures clamp(`ratio_x2`) into a pending register.
  - The pending value is applied at the next posedge-aligned period boundary. If not running, it is applied at the next posedge.
  - `cfg_ack` pulses for one cycle at the application posedge.
  - A second load before application overwrites the pending value. Only one `cfg_ack` is issued.
  - A load and an application in the same cycle: the newly loaded value stays pending.
- `clk_out` never produces a high or low phase shorter than min(old, new) phase length.
- States:
  - IDLE: `clk_out` = 0.
  - RUN.
  - DRAIN: `en` has dropped; the current period is finishing.
  - Transitions: IDLE→RUN on `en`. RUN→DRAIN on !`en`. DRAIN→IDLE at boundary. DRAIN→RUN if `en` is reasserted before the boundary.

## Timing
- Reset values:
  - `clk_out` = 0, `running` = 0, `cfg_ack` = 0.
  - Active R = clamp(`DEFAULT_RATIO_X2`). No ratio is pending.
- The negedge-stage flop also clears when `reset` is high, since it is synchronous to the falling edge.
- `clk_out` is low no later than the posedge at which `reset` is sampled, and it stays low until restart.
- Reset mid-operation discards any pending ratio. No `cfg_ack` is issued.
- Start latency: `clk_out` rises 0 cycles after the posedge that samples `en`.
- All counters are posedge-registered. The negedge path only retimes the posedge state by a half cycle.
- The counter wraps at the period boundary and never exceeds R−1 half-cycle ticks.

## Configuration
- `FRAC_DIV_DUAL_EDGE_EN` defined: behaviour is exactly as above.
- Not defined:
  - The negedge logic is removed. `ratio_x2[0]` is ignored, so the integer ratio is N = R/2, with a minimum of 1.
  - The high phase is ceil(N/2) T and the low phase is floor(N/2) T. All edges fall on posedges.
  - N = 1 holds `clk_out` high while running.

## Structure
- Package `frac_clk_div_pkg` holds:
  - the `RATIO_MIN_X2` = 2 constant;
  - the clamp function;
  - the state enum (IDLE/RUN/DRAIN).
- Sub-module `frac_edge_reg` contains the posedge flop, the negedge flop and the `clk`-select output mux that forms the dual-edge output stage.

## Test plan
- R = 3, `en` = 1: `clk_out` period is 1.5T, high 1T, low 0.5T. Edges alternate posedge and negedge.
- R = 6: high 1.5T, low 1.5T. Falls occur on negedges.
- R = 8: high 2T, low 2T. All edges fall on posedges.
- Load R = 8 while running at R = 3:
  - `cfg_ack` pulses at the next posedge boundary.
  - No phase is shorter than 0.5T.
  - The next period is 4T.
- Load `ratio_x2` = 0: clamped to 2. `clk_out` follows `clk`.
- Drop `en` mid-high at R = 8:
  - High completes (2T), then low completes (2T).
  - `running` clears, and `clk_out` stays 0.
- Assert `reset` mid-high with a pending load:
  - `clk_out` = 0 by the sampling posedge.
  - No `cfg_ack` is issued.
  - After reset, R = 3.
